fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Sits directly downstream of the voxel projection engine, between that engine's write stream (we/addr/data) and the single-port 64x64x8 framebuffer RAM.
- Buffers engine writes in a small FIFO and shares the one RAM port with video scan-out reads.
- Drains writes in free slots and returns the scanned-out pixel byte to the video path.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64
- AW, 12, framebuffer address width
- DW, 8, pixel data width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- display_on  in  1  visible-area flag from the video sync generator
- hpos  in  9  current horizontal pixel position
- vpos  in  9  current vertical pixel position
- wr_we  in  1  write request from the engine, one entry per cycle when high
- wr_addr  in  AW  engine write address
- wr_data  in  DW  engine write data
- wr_full  out  1  FIFO full (count==DEPTH)
- overflow  out  1  sticky flag: a request was dropped
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data; synchronous RAM, valid the cycle after the address is presented
- pixel  out  DW  scanned-out pixel byte

Behaviour:
- Reset (async, active-high) clears:
  - FIFO pointers and count
  - overflow, pixel, rd_pending
  - ram_we forced 0 while reset is high
- Video read address: vidaddr = {vpos[7:2], hpos[7:2]}, i.e. 4x pixel scaling from a 64x64 buffer.
- Read slot: display_on==1 && hpos[1:0]==2'b00. RAM port outputs are combinational from the current state.
- Read slot cycle:
  - ram_addr=vidaddr, ram_we=0, ram_wdata=0
  - rd_pending<=1
  - no FIFO pop
- Non-read-slot cycle, FIFO not empty:
  - ram_addr/ram_wdata = head entry, ram_we=1
  - head popped at the clock edge
- Non-read-slot cycle, FIFO empty: ram_we=0, ram_addr=vidaddr.
- Pixel capture:
  - When rd_pending==1, pixel<=ram_rdata at the edge ending that cycle; rd_pending then clears unless a new read slot occurs.
  - Latency: the read-slot cycle at edge T gives pixel updated at edge T+2.
  - pixel is held between captures.
  - When display_on==0, pixel<=0 on every edge and rd_pending<=0.
- Push rules:
  - Push when wr_we==1 and count<DEPTH at the start of the cycle.
  - If count==DEPTH, the request is dropped and overflow<=1, even if a pop happens the same cycle.
  - Simultaneous accepted push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- overflow clears only on reset.
- wr_full is combinational from count.
- Write drain ordering is strictly FIFO.
- Blanking (display_on==0): every cycle is a write slot, so the FIFO drains at 1 entry/cycle.
- Reset mid-operation:
  - Pending entries are discarded.
  - Any in-flight read is abandoned; no pixel update.

Optional Feature:
- Macro FB_WRITE_COALESCE_EN.
- Defined:
  - An accepted-condition request whose wr_addr equals the address of the most recently pushed, not-yet-popped entry overwrites that entry's data instead of pushing.
  - count is unchanged.
  - The request is not dropped even when full.
  - If that entry is being popped the same cycle, it is a normal push instead.
- Undefined: every request follows the plain push rules above.

Test Plan:
- Reset then idle, display_on=0 -> ram_we=0, pixel=0, overflow=0, wr_full=0.
- display_on=0, push 3 writes (0x010/0xAA, 0x011/0xBB, 0x012/0xCC) back-to-back -> ram_we high 3 consecutive cycles, in the same order, starting the cycle after the first push.
- display_on=1, ram model holding 0x5A at {vpos[7:2],hpos[7:2]}=0x041, hpos=4, vpos=4 -> ram_we=0 on that slot, pixel=0x5A two edges later, held for the 4-pixel span.
- DEPTH=8, display_on=1, 10 writes on consecutive cycles -> wr_full asserted, overflow=1, and only entries that found count<DEPTH reach the RAM, in order.
- Push and pop in the same cycle at count=3 -> count stays 3; wrap test of 20 writes through DEPTH=8 -> all data correct.
- FB_WRITE_COALESCE_EN, FIFO full, repeat write to the last pushed address 0x123 with 0x77 -> no overflow, a single RAM write of 0x77 to 0x123.

Source files
------------

// File: rtl/fb_write_arbiter.sv
`timescale 1ns/1ps
// fb_write_arbiter: buffers voxel-engine framebuffer writes in a FIFO and
// shares the single RAM port with 4x-scaled video scan-out reads.
// Ports: clk, reset (async, active-high); video timing display_on/hpos/vpos;
//   engine stream wr_we/wr_addr/wr_data -> wr_full, overflow (sticky);
//   RAM port ram_addr/ram_we/ram_wdata, ram_rdata (sync, 1-cycle);
//   pixel = scanned-out byte.
// Option: define FB_WRITE_COALESCE_EN to merge a write to the address of the
//   newest queued entry into that entry instead of pushing a new one.
module fb_write_arbiter #(
    parameter int DEPTH = 8,
    parameter int AW    = 12,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          display_on,
    input  logic [8:0]    hpos,
    input  logic [8:0]    vpos,
    input  logic          wr_we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_full,
    output logic          overflow,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] pixel
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          rd_pending_q, rd_pending_d;
    logic [DW-1:0] pixel_q, pixel_d;

    logic [AW-1:0] vidaddr;
    logic          read_slot;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          coal;
    logic          push;
    logic          drop;

    // hpos[8]/vpos[8] are outside the 64x64 scaled window.
    logic unused_pos;
    assign unused_pos = &{1'b0, hpos[8], vpos[8]};

    // 4x scaling: each buffer pixel covers a 4x4 screen block.
    assign vidaddr    = AW'({vpos[7:2], hpos[7:2]});
    assign read_slot  = display_on && (hpos[1:0] == 2'b00);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign pop        = !read_slot && !fifo_empty;

`ifdef FB_WRITE_COALESCE_EN
    logic [PW-1:0] tail_idx;
    assign tail_idx = wr_ptr_q - 1'b1;
    // The newest entry is only mergeable if it is not leaving this cycle;
    // with count==1 the head and the newest entry are the same slot.
    assign coal = wr_we
               && !fifo_empty
               && (addr_mem[tail_idx] == wr_addr)
               && !(pop && (count_q == CW'(1)));
`else
    assign coal = 1'b0;
`endif

    // Fullness is judged on the count at the start of the cycle, so a
    // request at full is dropped even if a pop frees a slot this cycle.
    assign push = wr_we && !coal && !fifo_full;
    assign drop = wr_we && !coal && fifo_full;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q | drop;
    end

    // A read issued in a slot returns data one cycle later; capture it at
    // the end of that following cycle.
    always_comb begin
        pixel_d      = pixel_q;
        rd_pending_d = 1'b0;
        if (!display_on) begin
            pixel_d      = '0;
            rd_pending_d = 1'b0;
        end else begin
            if (rd_pending_q) begin
                pixel_d = ram_rdata;
            end
            rd_pending_d = read_slot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            rd_pending_q <= 1'b0;
            pixel_q      <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            rd_pending_q <= rd_pending_d;
            pixel_q      <= pixel_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= wr_addr;
            data_mem[wr_ptr_q] <= wr_data;
        end
`ifdef FB_WRITE_COALESCE_EN
        if (coal) begin
            data_mem[tail_idx] <= wr_data;
        end
`endif
    end

    always_comb begin
        ram_we    = pop && !reset;
        ram_addr  = vidaddr;
        ram_wdata = '0;
        if (pop) begin
            ram_addr  = addr_mem[rd_ptr_q];
            ram_wdata = data_mem[rd_ptr_q];
        end
    end

    assign wr_full  = fifo_full;
    assign overflow = overflow_q;
    assign pixel    = pixel_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
`timescale 1ns/1ps
// Bench for fb_write_arbiter: queue-based reference model,
// per-cycle comparison of all outputs plus directed checks.
module tb_fb_write_arbiter;
    localparam int DEPTH = 8;
    localparam int AW    = 12;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          display_on = 1'b0;
    logic [8:0]    hpos = '0;
    logic [8:0]    vpos = '0;
    logic          wr_we = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_full, overflow, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata, pixel;

    always #5 clk = ~clk;

    fb_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .display_on(display_on),
        .hpos(hpos), .vpos(vpos), .wr_we(wr_we),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
        .overflow(overflow), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pixel(pixel)
    );

    function automatic logic [7:0] init_val(input logic [11:0] a);
        return (a == 12'h041) ? 8'h5A : (a[7:0] ^ 8'h3C);
    endfunction

    logic [7:0] ram_mem [4096];
    bit         ram_v   [4096];
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            ram_v[ram_addr]   <= 1'b1;
        end
        ram_rdata <= ram_v[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
    end

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t       q[$];
    logic [7:0] sh_mem [4096];
    bit         sh_v   [4096];
    bit         m_ovf, m_pend;
    logic [7:0] m_pix, m_pval;
    bit         c_we, c_don, d_pop, d_rs;
    logic [11:0] c_a, c_vid;
    logic [7:0] c_d;
    logic [30:0] exp_v;
    wire  [30:0] obs = {ram_we, ram_addr, ram_wdata, wr_full, overflow, pixel};
    int vecs = 0;
    int errs = 0;

    logic [11:0] ta [3] = '{12'h010, 12'h011, 12'h012};
    logic [7:0]  td [3] = '{8'hAA, 8'hBB, 8'hCC};

    function automatic logic [7:0] sh_rd(input logic [11:0] a);
        return sh_v[a] ? sh_mem[a] : init_val(a);
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_pix  = 8'h00;
        m_pend = 1'b0;
    endtask

    // Drive one cycle's inputs and form the expected outputs.
    task automatic cyc(input bit we, input logic [11:0] a,
                       input logic [7:0] d, input bit don,
                       input logic [8:0] h, input logic [8:0] v);
        wr_we = we; wr_addr = a; wr_data = d;
        display_on = don; hpos = h; vpos = v;
        c_we = we; c_a = a; c_d = d; c_don = don;
        c_vid = {v[7:2], h[7:2]};
        d_rs  = don && (h[1:0] == 2'b00);
        d_pop = !d_rs && (q.size() > 0);
        #2;
        if (d_pop)
            exp_v = {1'b1, q[0].a, q[0].d, q.size() == DEPTH, m_ovf, m_pix};
        else
            exp_v = {1'b0, c_vid, 8'h00, q.size() == DEPTH, m_ovf, m_pix};
    endtask

    // Advance the model across the clock edge.
    task automatic adv();
        ent_t e;
        int   sz;
        bit   coal;
        @(posedge clk);
        sz   = q.size();
        coal = 1'b0;
`ifdef FB_WRITE_COALESCE_EN
        if (c_we && sz > 0 && q[sz-1].a == c_a && !(d_pop && sz == 1)) begin
            q[sz-1].d = c_d;
            coal = 1'b1;
        end
`endif
        if (d_pop) begin
            e = q.pop_front();
            sh_mem[e.a] = e.d;
            sh_v[e.a]   = 1'b1;
        end
        if (c_we && !coal) begin
            if (sz < DEPTH) begin
                e.a = c_a;
                e.d = c_d;
                q.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (!c_don) begin
            m_pix  = 8'h00;
            m_pend = 1'b0;
        end else begin
            if (m_pend) m_pix = m_pval;
            m_pend = d_rs;
            if (d_rs) m_pval = sh_rd(c_vid);
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        vecs++;
        if (ram_we !== 1'b0) begin
            errs++;
            $display("FAIL reset_we: got %b exp 0", ram_we);
        end
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 12'h0, 8'h0, 0, 9'd0, 9'd0);
            vecs++;
            if ({ram_we, wr_full, overflow, pixel} !== 11'h0) begin
                errs++;
                $display("FAIL reset_idle: got %h exp 0",
                         {ram_we, wr_full, overflow, pixel});
            end
            vecs++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL reset_model: got %h exp %h", obs, exp_v);
            end
            adv();
        end
    endtask

    task automatic test_burst();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) cyc(1, ta[i], td[i], 0, 9'd0, 9'd0);
            else       cyc(0, 12'h0, 8'h0, 0, 9'd0, 9'd0);
            vecs++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL burst_model: got %h exp %h", obs, exp_v);
            end
            vecs++;
            if (i >= 1 && i <= 3) begin
                if ({ram_we, ram_addr, ram_wdata} !== {1'b1, ta[i-1], td[i-1]}) begin
                    errs++;
                    $display("FAIL burst_order: got %h exp %h",
                             {ram_we, ram_addr, ram_wdata},
                             {1'b1, ta[i-1], td[i-1]});
                end
            end else if (ram_we !== 1'b0) begin
                errs++;
                $display("FAIL burst_idle: got we=%b exp 0", ram_we);
            end
            adv();
        end
    endtask

    task automatic test_pixel();
        for (int h = 0; h < 12; h++) begin
            cyc(0, 12'h0, 8'h0, 1, 9'(h), 9'd4);
            vecs++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL pixel_model: got %h exp %h", obs, exp_v);
            end
            if (h >= 6 && h <= 9) begin
                vecs++;
                if (pixel !== 8'h5A) begin
                    errs++;
                    $display("FAIL pixel_span: h=%0d got %h exp 5a", h, pixel);
                end
            end
            adv();
        end
    endtask

    task automatic drain(input int n, output int nw,
                         output logic [11:0] wa [32],
                         output logic [7:0] wd [32]);
        nw = 0;
        for (int i = 0; i < n; i++) begin
            cyc(0, 12'h0, 8'h0, 0, 9'd0, 9'd0);
            vecs++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL drain_model: got %h exp %h", obs, exp_v);
            end
            if (ram_we === 1'b1 && nw < 32) begin
                wa[nw] = ram_addr;
                wd[nw] = ram_wdata;
                nw++;
            end
            adv();
        end
    endtask

    task automatic test_overflow();
        int          nw;
        logic [11:0] wa [32];
        logic [7:0]  wd [32];
        for (int i = 0; i < 10; i++) begin
            cyc(1, 12'(12'h100 + i), 8'($urandom), 1, 9'd0, 9'd0);
            vecs++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL ovf_model: got %h exp %h", obs, exp_v);
            end
            adv();
        end
        cyc(0, 12'h0, 8'h0, 1, 9'd0, 9'd0);
        vecs++;
        if ({wr_full, overflow} !== 2'b11) begin
            errs++;
            $display("FAIL ovf_flags: got %b exp 11", {wr_full, overflow});
        end
        adv();
        drain(12, nw, wa, wd);
        vecs++;
        if (nw !== 8) begin
            errs++;
            $display("FAIL ovf_count: got %0d exp 8", nw);
        end
        for (int k = 0; k < 8 && k < nw; k++) begin
            vecs++;
            if (wa[k] !== 12'(12'h100 + k)) begin
                errs++;
                $display("FAIL ovf_order: k=%0d got %h exp %h",
                         k, wa[k], 12'(12'h100 + k));
            end
        end
    endtask

    task automatic test_same_cycle();
        int          nw;
        logic [11:0] wa [32];
        logic [7:0]  wd [32];
        for (int i = 0; i < 3; i++) begin
            cyc(1, 12'(12'h300 + i), 8'($urandom), 1, 9'd0, 9'd0);
            vecs++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL pp_model: got %h exp %h", obs, exp_v);
            end
            adv();
        end
        cyc(1, 12'h303, 8'h33, 1, 9'd1, 9'd0);
        vecs++;
        if (obs !== exp_v) begin
            errs++;
            $display("FAIL pp_both: got %h exp %h", obs, exp_v);
        end
        adv();
        for (int k = 0; k < 6; k++) begin
            cyc(k < 5, 12'(12'h310 + k), 8'($urandom), 1, 9'd0, 9'd0);
            vecs++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL pp_fill: got %h exp %h", obs, exp_v);
            end
            if (k == 4 || k == 5) begin
                vecs++;
                if (wr_full !== (k == 5)) begin
                    errs++;
                    $display("FAIL pp_full: k=%0d got %b exp %b",
                             k, wr_full, k == 5);
                end
            end
            adv();
        end
        drain(10, nw, wa, wd);
    endtask

    task automatic test_wrap();
        int          nw;
        int          n;
        logic [7:0]  dv [20];
        n = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) begin
                dv[i] = 8'($urandom);
                cyc(1, 12'(12'h400 + i), dv[i], 0, 9'd0, 9'd0);
            end else begin
                cyc(0, 12'h0, 8'h0, 0, 9'd0, 9'd0);
            end
            vecs++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL wrap_model: got %h exp %h", obs, exp_v);
            end
            if (ram_we === 1'b1 && n < 20) begin
                vecs++;
                if ({ram_addr, ram_wdata} !== {12'(12'h400 + n), dv[n]}) begin
                    errs++;
                    $display("FAIL wrap_data: n=%0d got %h exp %h", n,
                             {ram_addr, ram_wdata}, {12'(12'h400 + n), dv[n]});
                end
                n++;
            end
            adv();
        end
        nw = n;
        vecs++;
        if (nw !== 20) begin
            errs++;
            $display("FAIL wrap_count: got %0d exp 20", nw);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 12'(12'h500 + i), 8'($urandom), 1, 9'd0, 9'd0);
            adv();
        end
        cyc(0, 12'h0, 8'h0, 1, 9'd0, 9'd0);
        vecs++;
        if (obs !== exp_v) begin
            errs++;
            $display("FAIL rmid_model: got %h exp %h", obs, exp_v);
        end
        #1 reset = 1'b1;
        model_reset();
        #1;
        vecs++;
        if ({ram_we, wr_full, overflow, pixel} !== 11'h0) begin
            errs++;
            $display("FAIL rmid_clear: got %h exp 0",
                     {ram_we, wr_full, overflow, pixel});
        end
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 12'h0, 8'h0, i < 2, 9'd1, 9'd0);
            vecs++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL rmid_after: got %h exp %h", obs, exp_v);
            end
            adv();
        end
    endtask

    task automatic test_random();
        int h = 0;
        int v = 0;
        bit line_on = 1'b1;
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom % 10) < 6, {8'h05, 4'($urandom % 4)},
                8'($urandom), line_on && (h < 64), 9'(h), 9'(v));
            vecs++;
            if (obs !== exp_v) begin
                errs++;
                $display("FAIL random: i=%0d got %h exp %h", i, obs, exp_v);
            end
            adv();
            h++;
            if (h == 80) begin
                h = 0;
                v++;
                line_on = ($urandom % 5) != 0;
            end
        end
    endtask

`ifdef FB_WRITE_COALESCE_EN
    task automatic test_coalesce();
        int          nw;
        int          n123;
        logic [7:0]  last;
        logic [11:0] wa [32];
        logic [7:0]  wd [32];
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, (i == 7) ? 12'h123 : 12'(12'h200 + i), 8'(i), 1, 9'd0, 9'd0);
            adv();
        end
        cyc(1, 12'h123, 8'h77, 1, 9'd0, 9'd0);
        vecs++;
        if (obs !== exp_v) begin
            errs++;
            $display("FAIL coal_model: got %h exp %h", obs, exp_v);
        end
        adv();
        cyc(0, 12'h0, 8'h0, 1, 9'd0, 9'd0);
        vecs++;
        if (overflow !== 1'b0) begin
            errs++;
            $display("FAIL coal_ovf: got %b exp 0", overflow);
        end
        adv();
        drain(12, nw, wa, wd);
        n123 = 0;
        last = 8'h00;
        for (int k = 0; k < nw; k++) begin
            if (wa[k] == 12'h123) begin
                n123++;
                last = wd[k];
            end
        end
        vecs++;
        if ({n123 == 1, last} !== {1'b1, 8'h77}) begin
            errs++;
            $display("FAIL coal_write: got n=%0d d=%h exp n=1 d=77", n123, last);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_burst();
        test_pixel();
        test_overflow();
        test_same_cycle();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef FB_WRITE_COALESCE_EN
        test_coalesce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
